// File: rtl/knn_system.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : knn_system                                                   |
// | Description : Streaming k-nearest-neighbour classifier: per-sample L1       |
// |               distance (squared L2 with KNN_SQUARED_DIST_EN), sorted K-list,|
// |               majority vote over 2^L training samples.                      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module knn_system #(
  parameter int M            = 5,
  parameter int N            = 10,
  parameter int W            = 32,
  parameter int MAX_ELEMENTS = 32,
  parameter int TYPE_W       = 3,
  parameter int K            = 7,
  parameter int L            = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read_done,
  input  logic [W*M*N-1:0]    training_data,
  input  logic [TYPE_W-1:0]   training_data_type,
  input  logic [W*M*N-1:0]    input_data,
  output logic                data_request,
  output logic                done,
  output logic                done_calc,
  output logic [TYPE_W-1:0]   inferred_type,
  output logic                inference_done
);
  localparam int c_NE = M * N;
`ifdef KNN_SQUARED_DIST_EN
  localparam int c_TERM_W = 2 * W;
`else
  localparam int c_TERM_W = W;
`endif
  localparam int c_ACC_W  = c_TERM_W + $clog2(c_NE) + 1;
  localparam int c_IDX_W  = $clog2(c_NE + 1);
  localparam int c_EI_W   = (c_NE > 1) ? $clog2(c_NE) : 1;
  localparam int c_KI_W   = $clog2(K + 1);
  localparam int c_NLAB   = 2 ** TYPE_W;
  localparam int c_NS     = 2 ** L;
  localparam int c_CNT_W  = L + 1;

  if (MAX_ELEMENTS < 1 || K < 1 || K > c_NS) begin : g_param_check
    $error("knn_system: illegal MAX_ELEMENTS/K/L combination");
  end

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ACCUM      = 3'd1,
    INSERT     = 3'd2,
    VOTE_COUNT = 3'd3,
    VOTE_PICK  = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic [W*c_NE-1:0]  r_train, r_query;
  logic [TYPE_W-1:0]  r_type;
  logic [c_IDX_W-1:0] r_idx;
  logic [c_TERM_W-1:0] r_term;
  logic [c_ACC_W-1:0] r_acc;
  logic [c_ACC_W-1:0] r_list_d [K];
  logic [TYPE_W-1:0]  r_list_t [K];
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_KI_W-1:0]  r_vidx;
  logic [TYPE_W-1:0]  r_lidx;
  logic [c_KI_W-1:0]  r_votes [c_NLAB];
  logic [c_KI_W-1:0]  r_best_cnt;
  logic [TYPE_W-1:0]  r_best_lab;
  logic               r_done, r_done_calc, r_inf_done;
  logic [TYPE_W-1:0]  r_inferred;

  logic [W-1:0]        w_tr_e [c_NE];
  logic [W-1:0]        w_in_e [c_NE];
  logic [c_EI_W-1:0]   w_eidx;
  logic [W-1:0]        w_a, w_b, w_diff;
  logic [c_TERM_W-1:0] w_term;
  logic [K-1:0]        w_lt;
  logic [c_ACC_W-1:0]  w_ins_d [K];
  logic [TYPE_W-1:0]   w_ins_t [K];
  logic                w_last_sample;
  logic [c_KI_W-1:0]   w_pick_cnt;
  logic [TYPE_W-1:0]   w_pick_lab;

  for (genvar e = 0; e < c_NE; e++) begin : g_unpack
    assign w_tr_e[e] = r_train[W*(e+1)-1 -: W];
    assign w_in_e[e] = r_query[W*(e+1)-1 -: W];
  end

  // Index is clamped on the drain cycle, whose term is discarded anyway.
  assign w_eidx = (r_idx < c_IDX_W'(c_NE)) ? c_EI_W'(r_idx) : '0;
  assign w_a    = w_tr_e[w_eidx];
  assign w_b    = w_in_e[w_eidx];
  assign w_diff = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
`ifdef KNN_SQUARED_DIST_EN
  assign w_term = c_TERM_W'(w_diff) * c_TERM_W'(w_diff);
`else
  assign w_term = w_diff;
`endif

  // Strict compare so an equal distance lands behind existing entries.
  for (genvar k = 0; k < K; k++) begin : g_cmp
    assign w_lt[k] = (r_acc < r_list_d[k]);
  end

  always_comb begin
    for (int k = 0; k < K; k++) begin
      w_ins_d[k] = r_list_d[k];
      w_ins_t[k] = r_list_t[k];
    end
    if (w_lt[0]) begin
      w_ins_d[0] = r_acc;
      w_ins_t[0] = r_type;
    end
    for (int k = 1; k < K; k++) begin
      if (w_lt[k]) begin
        if (w_lt[k-1]) begin
          w_ins_d[k] = r_list_d[k-1];
          w_ins_t[k] = r_list_t[k-1];
        end else begin
          w_ins_d[k] = r_acc;
          w_ins_t[k] = r_type;
        end
      end
    end
  end

  assign w_last_sample = (r_cnt == c_CNT_W'(c_NS - 1));
  assign w_pick_cnt    = (r_votes[r_lidx] > r_best_cnt) ? r_votes[r_lidx] : r_best_cnt;
  assign w_pick_lab    = (r_votes[r_lidx] > r_best_cnt) ? r_lidx : r_best_lab;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (read_done) w_next = ACCUM;
      ACCUM:      if (r_idx == c_IDX_W'(c_NE)) w_next = INSERT;
      INSERT:     w_next = w_last_sample ? VOTE_COUNT : IDLE;
      VOTE_COUNT: if (r_vidx == c_KI_W'(K - 1)) w_next = VOTE_PICK;
      VOTE_PICK:  if (r_lidx == TYPE_W'(c_NLAB - 1)) w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_train     <= '0;
      r_query     <= '0;
      r_type      <= '0;
      r_idx       <= '0;
      r_term      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_vidx      <= '0;
      r_lidx      <= '0;
      r_best_cnt  <= '0;
      r_best_lab  <= '0;
      r_done      <= 1'b0;
      r_done_calc <= 1'b0;
      r_inf_done  <= 1'b0;
      r_inferred  <= '0;
      for (int k = 0; k < K; k++) begin
        r_list_d[k] <= '1;
        r_list_t[k] <= '0;
      end
      for (int l = 0; l < c_NLAB; l++) r_votes[l] <= '0;
    end else begin
      r_done      <= 1'b0;
      r_done_calc <= 1'b0;
      r_inf_done  <= 1'b0;
      case (r_state)
        IDLE: if (read_done) begin
          r_train <= training_data;
          r_query <= input_data;
          r_type  <= training_data_type;
          r_idx   <= '0;
          r_term  <= '0;
          r_acc   <= '0;
        end
        // One-stage pipeline: term of element e is added on the following cycle.
        ACCUM: begin
          r_acc  <= r_acc + c_ACC_W'(r_term);
          r_term <= (r_idx < c_IDX_W'(c_NE)) ? w_term : '0;
          r_idx  <= r_idx + c_IDX_W'(1);
        end
        INSERT: begin
          r_done <= 1'b1;
          r_cnt  <= r_cnt + c_CNT_W'(1);
          for (int k = 0; k < K; k++) begin
            r_list_d[k] <= w_ins_d[k];
            r_list_t[k] <= w_ins_t[k];
          end
          if (w_last_sample) begin
            r_done_calc <= 1'b1;
            r_vidx      <= '0;
            r_best_cnt  <= '0;
            r_best_lab  <= '0;
          end
        end
        VOTE_COUNT: begin
          r_votes[r_list_t[r_vidx]] <= r_votes[r_list_t[r_vidx]] + c_KI_W'(1);
          r_vidx <= r_vidx + c_KI_W'(1);
          r_lidx <= '0;
        end
        VOTE_PICK: begin
          r_best_cnt <= w_pick_cnt;
          r_best_lab <= w_pick_lab;
          r_lidx     <= r_lidx + TYPE_W'(1);
          if (r_lidx == TYPE_W'(c_NLAB - 1)) begin
            r_inferred <= w_pick_lab;
            r_inf_done <= 1'b1;
            r_cnt      <= '0;
            for (int k = 0; k < K; k++) begin
              r_list_d[k] <= '1;
              r_list_t[k] <= '0;
            end
            for (int l = 0; l < c_NLAB; l++) r_votes[l] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_request   = (r_state == IDLE);
  assign done           = r_done;
  assign done_calc      = r_done_calc;
  assign inference_done = r_inf_done;
  assign inferred_type  = r_inferred;

endmodule
`default_nettype wire

// File: tb/tb_knn_system.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_knn_system                                                |
// | Description : Directed self-checking bench for knn_system (default build). |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_knn_system;
  localparam int M = 5, N = 10, W = 32, TYPE_W = 3, K = 7, L = 6;
  localparam int NE = M * N;
  localparam int NS = 2 ** L;

  logic                clk = 1'b0;
  logic                rst;
  logic                read_done;
  logic [W*NE-1:0]     training_data;
  logic [TYPE_W-1:0]   training_data_type;
  logic [W*NE-1:0]     input_data;
  logic                data_request, done, done_calc, inference_done;
  logic [TYPE_W-1:0]   inferred_type;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_calc  = 0;
  int n_inf   = 0;

  knn_system #(
    .M(M), .N(N), .W(W), .MAX_ELEMENTS(32), .TYPE_W(TYPE_W), .K(K), .L(L)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .read_done          (read_done),
    .training_data      (training_data),
    .training_data_type (training_data_type),
    .input_data         (input_data),
    .data_request       (data_request),
    .done               (done),
    .done_calc          (done_calc),
    .inferred_type      (inferred_type),
    .inference_done     (inference_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done)           n_done <= n_done + 1;
    if (done_calc)      n_calc <= n_calc + 1;
    if (inference_done) n_inf  <= n_inf + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W*NE-1:0] fill(input int v);
    logic [W*NE-1:0] r;
    r = '0;
    for (int e = 0; e < NE; e++) r[W*e +: W] = W'(v);
    return r;
  endfunction

  // mode 0: s/20+1; 1: tie pattern around 25; 2: 0 below 32 else 7
  function automatic int label_of(input int mode, input int s);
    if (mode == 0) return s / 20 + 1;
    if (mode == 1) begin
      if (s == 24 || s == 25 || s == 26) return 1;
      if (s == 22 || s == 23 || s == 27) return 2;
      if (s == 28) return 3;
      return 0;
    end
    return (s < 32) ? 0 : 7;
  endfunction

  task automatic send(input int tv, input int lab, input int qv, input bit poke,
                      output int lat, output logic calc);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!data_request && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!data_request) check_val("request_timeout", data_request, 1);
    training_data      = fill(tv);
    training_data_type = TYPE_W'(lab);
    input_data         = fill(qv);
    read_done          = 1'b1;
    @(posedge clk);
    #1;
    read_done = 1'b0;
    lat = 0;
    while (lat < 200 && !done) begin
      if (poke && lat == 5) begin
        check_val("request_low_accum", data_request, 0);
        training_data      = fill(1000);
        input_data         = fill(1000);
        training_data_type = TYPE_W'(5);
        read_done          = 1'b1;
      end else begin
        read_done = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    read_done = 1'b0;
    if (!done) check_val("done_timeout", done, 1);
    calc = done_calc;
  endtask

  task automatic run(input int qv, input int mode, input int exp_type, input int prev_type);
    int lat, v, bad_lat, bad_calc, c0, i0;
    logic calc;
    bad_lat  = 0;
    bad_calc = 0;
    c0 = n_calc;
    i0 = n_inf;
    for (int s = 0; s < NS; s++) begin
      send(s, label_of(mode, s), qv, (s == 1), lat, calc);
      if (s == 0) check_val("latency_first", lat, 52);
      if (lat != 52) bad_lat++;
      if (calc !== (s == NS - 1)) bad_calc++;
    end
    check_val("latency_all", bad_lat, 0);
    check_val("done_calc_timing", bad_calc, 0);
    check_val("type_held", inferred_type, prev_type);
    v = 0;
    while (v < 100 && !inference_done) begin
      @(posedge clk);
      #1;
      v++;
    end
    check_val("vote_latency", v, K + 2 ** TYPE_W);
    check_val("inferred_type", inferred_type, exp_type);
    @(posedge clk);
    #1;
    check_val("done_calc_count", n_calc - c0, 1);
    check_val("inference_count", n_inf - i0, 1);
  endtask

  initial begin
    int lat, d0, c0, i0;
    logic calc;
    rst                = 1'b1;
    read_done          = 1'b0;
    training_data      = '0;
    training_data_type = '0;
    input_data         = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_data_request", data_request, 1);
    check_val("rst_done", done, 0);
    check_val("rst_done_calc", done_calc, 0);
    check_val("rst_inference_done", inference_done, 0);
    check_val("rst_inferred_type", inferred_type, 0);
    @(negedge clk);
    rst = 1'b0;

    run(25, 0, 2, 0);
    run(60, 0, 4, 2);
    run(25, 1, 1, 4);
    run(10, 2, 0, 1);

    // Partial run of exact-match samples labelled 6, then reset mid-sample.
    for (int s = 0; s < 30; s++) send(s, 6, s, 1'b0, lat, calc);
    @(negedge clk);
    training_data = fill(30);
    input_data    = fill(30);
    read_done     = 1'b1;
    @(posedge clk);
    #1;
    read_done = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    d0 = n_done;
    c0 = n_calc;
    i0 = n_inf;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("midrst_data_request", data_request, 1);
    check_val("midrst_inferred_type", inferred_type, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check_val("midrst_no_done", n_done - d0, 0);
    check_val("midrst_no_calc", n_calc - c0, 0);
    check_val("midrst_no_infer", n_inf - i0, 0);

    run(40, 0, 3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
